register_file: RTL and testbench

- Responder side of the ID-stage register read interface: 32 x 32-bit general register file with two combinational read ports (rs, rt) and one write port driven by writeback.
- Holds a per-register pending-write scoreboard. ID issue marks destinations in flight; writeback retires them. The block raises hazard flags so the pipeline can stall.
- Sits between the ID stage (read addresses in, read data out) and the WB stage (write in).

---
 rtl/register_file_pkg.sv | 13 +
 rtl/regfile_scoreboard.sv | 70 +++++++
 rtl/register_file.sv | 88 ++++++++
 tb/tb_register_file.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// Shared constants and types for the ID-stage register file and its
// pending-write scoreboard.
package register_file_pkg;

  localparam int RF_DATA_W    = 32;
  localparam int RF_ADDR_W    = 5;
  localparam int RF_PEND_W    = 2;
  localparam int RF_REG_COUNT = 1 << RF_ADDR_W;
  localparam int RF_REG_ZERO  = 0;

  typedef logic [RF_PEND_W-1:0] pend_cnt_t;

endpackage : register_file_pkg

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write counters, sticky overflow flag and the
// read-port hazard flags. Register 0 is never tracked.
module regfile_scoreboard
  import register_file_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int PEND_W = RF_PEND_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_dest,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_add,
  input  logic [ADDR_W-1:0] rs_add,
  input  logic [ADDR_W-1:0] rt_add,
  output logic              hazard_rs,
  output logic              hazard_rt,
  output logic              pend_overflow
);

  localparam int                REG_COUNT = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ADD_ZERO  = ADDR_W'(RF_REG_ZERO);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);

  logic [PEND_W-1:0] pend_q [REG_COUNT];
  logic [PEND_W-1:0] pend_d [REG_COUNT];
  logic              ovf_q;
  logic              ovf_d;

  // Next counter values: simultaneous issue and retire cancel out.
  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    for (int r = 1; r < REG_COUNT; r++) begin
      if (issue_valid && issue_dest == ADDR_W'(r) &&
          !(wb_en && wb_add == ADDR_W'(r))) begin
        if (pend_q[r] == PEND_MAX) ovf_d = 1'b1;
        else                       pend_d[r] = pend_q[r] + 1'b1;
      end else if (wb_en && wb_add == ADDR_W'(r) &&
                   !(issue_valid && issue_dest == ADDR_W'(r))) begin
        // A retire with nothing in flight is an untracked write; hold at 0.
        if (pend_q[r] != '0) pend_d[r] = pend_q[r] - 1'b1;
      end
    end
  end

  // Counter and overflow state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < REG_COUNT; r++) pend_q[r] <= '0;
      ovf_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  // Hazard unless the last outstanding write is being bypassed this cycle.
  always_comb begin
    hazard_rs = (rs_add != ADD_ZERO) && (pend_q[rs_add] != '0) &&
                !((pend_q[rs_add] == PEND_ONE) && wb_en && (wb_add == rs_add));
    hazard_rt = (rt_add != ADD_ZERO) && (pend_q[rt_add] != '0) &&
                !((pend_q[rt_add] == PEND_ONE) && wb_en && (wb_add == rt_add));
  end

  assign pend_overflow = ovf_q;

endmodule : regfile_scoreboard

// File: rtl/register_file.sv
// 32 x 32 general register file: two combinational read ports with
// write-through bypass, one writeback port, pending-write scoreboard.
// Optional macro REGFILE_DEBUG_PORT_EN adds a raw (unbypassed) third
// read port Dbg_Add/Dbg_Data for board display.
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int PEND_W = RF_PEND_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] RegAdd_rs,
  input  logic [ADDR_W-1:0] RegAdd_rt,
  output logic [DATA_W-1:0] RegData_rs,
  output logic [DATA_W-1:0] RegData_rt,
  input  logic              WB_WriteEn,
  input  logic [ADDR_W-1:0] WB_WriteAdd,
  input  logic [DATA_W-1:0] WB_WriteData,
  input  logic              Issue_Valid,
  input  logic [ADDR_W-1:0] Issue_DestAdd,
  output logic              Hazard_rs,
  output logic              Hazard_rt,
`ifdef REGFILE_DEBUG_PORT_EN
  input  logic [ADDR_W-1:0] Dbg_Add,
  output logic [DATA_W-1:0] Dbg_Data,
`endif
  output logic              Pend_Overflow
);

  localparam int                REG_COUNT = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ADD_ZERO  = ADDR_W'(RF_REG_ZERO);

  logic [DATA_W-1:0] regs_q [REG_COUNT];
  logic [DATA_W-1:0] regs_d [REG_COUNT];
  logic              wb_live;

  assign wb_live = WB_WriteEn && (WB_WriteAdd != ADD_ZERO);

  // Array update; register 0 is never written so it stays at its reset 0.
  always_comb begin
    regs_d = regs_q;
    if (wb_live) regs_d[WB_WriteAdd] = WB_WriteData;
  end

  // Storage array.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < REG_COUNT; r++) regs_q[r] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports with same-cycle writeback bypass.
  always_comb begin
    if (RegAdd_rs == ADD_ZERO)                    RegData_rs = '0;
    else if (wb_live && WB_WriteAdd == RegAdd_rs) RegData_rs = WB_WriteData;
    else                                          RegData_rs = regs_q[RegAdd_rs];
    if (RegAdd_rt == ADD_ZERO)                    RegData_rt = '0;
    else if (wb_live && WB_WriteAdd == RegAdd_rt) RegData_rt = WB_WriteData;
    else                                          RegData_rt = regs_q[RegAdd_rt];
  end

`ifdef REGFILE_DEBUG_PORT_EN
  // Raw array contents, deliberately without bypass.
  assign Dbg_Data = regs_q[Dbg_Add];
`endif

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .PEND_W (PEND_W)
  ) u_scoreboard (
    .clock         (clock),
    .reset         (reset),
    .issue_valid   (Issue_Valid),
    .issue_dest    (Issue_DestAdd),
    .wb_en         (WB_WriteEn),
    .wb_add        (WB_WriteAdd),
    .rs_add        (RegAdd_rs),
    .rt_add        (RegAdd_rt),
    .hazard_rs     (Hazard_rs),
    .hazard_rt     (Hazard_rt),
    .pend_overflow (Pend_Overflow)
  );

endmodule : register_file

// File: tb/tb_register_file.sv
// Directed bench for register_file. Inputs change on the falling edge and
// outputs are checked 1 ns later, well away from the rising edge.
module tb_register_file;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  RegAdd_rs, RegAdd_rt;
  logic [31:0] RegData_rs, RegData_rt;
  logic        WB_WriteEn;
  logic [4:0]  WB_WriteAdd;
  logic [31:0] WB_WriteData;
  logic        Issue_Valid;
  logic [4:0]  Issue_DestAdd;
  logic        Hazard_rs, Hazard_rt, Pend_Overflow;
`ifdef REGFILE_DEBUG_PORT_EN
  logic [4:0]  Dbg_Add;
  logic [31:0] Dbg_Data;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  register_file dut (
    .clock         (clock),
    .reset         (reset),
    .RegAdd_rs     (RegAdd_rs),
    .RegAdd_rt     (RegAdd_rt),
    .RegData_rs    (RegData_rs),
    .RegData_rt    (RegData_rt),
    .WB_WriteEn    (WB_WriteEn),
    .WB_WriteAdd   (WB_WriteAdd),
    .WB_WriteData  (WB_WriteData),
    .Issue_Valid   (Issue_Valid),
    .Issue_DestAdd (Issue_DestAdd),
    .Hazard_rs     (Hazard_rs),
    .Hazard_rt     (Hazard_rt),
`ifdef REGFILE_DEBUG_PORT_EN
    .Dbg_Add       (Dbg_Add),
    .Dbg_Data      (Dbg_Data),
`endif
    .Pend_Overflow (Pend_Overflow)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Move to the next falling edge and clear the strobes.
  task automatic next_cycle();
    @(negedge clock);
    WB_WriteEn  = 1'b0;
    Issue_Valid = 1'b0;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b0;
    RegAdd_rs = '0; RegAdd_rt = '0;
    WB_WriteEn = 1'b0; WB_WriteAdd = '0; WB_WriteData = '0;
    Issue_Valid = 1'b0; Issue_DestAdd = '0;
`ifdef REGFILE_DEBUG_PORT_EN
    Dbg_Add = '0;
`endif
    #12 reset = 1'b1;

    // Reset state
    next_cycle();
    RegAdd_rs = 5'd3; RegAdd_rt = 5'd7; settle();
    check_eq("rst_rs", RegData_rs, 32'h0);
    check_eq("rst_rt", RegData_rt, 32'h0);
    check_eq("rst_haz", {30'b0, Hazard_rs, Hazard_rt}, 32'h0);
    check_eq("rst_ovf", {31'b0, Pend_Overflow}, 32'h0);

    // r5 holds a value, then reset lands on a second write to r5
    WB_WriteEn = 1'b1; WB_WriteAdd = 5'd5; WB_WriteData = 32'hDEADBEEF;
    next_cycle();
    RegAdd_rs = 5'd5; settle();
    check_eq("r5_pre", RegData_rs, 32'hDEADBEEF);
    WB_WriteEn = 1'b1; WB_WriteAdd = 5'd5; WB_WriteData = 32'hCAFEF00D;
    #2 reset = 1'b0;
    @(posedge clock);
    #2 reset = 1'b1;
    next_cycle();
    RegAdd_rs = 5'd5; settle();
    check_eq("r5_rst", RegData_rs, 32'h0);

    // Write-through bypass on both ports, then stored value
    WB_WriteEn = 1'b1; WB_WriteAdd = 5'd4; WB_WriteData = 32'h12345678;
    RegAdd_rs = 5'd4; RegAdd_rt = 5'd4; settle();
    check_eq("byp_rs", RegData_rs, 32'h12345678);
    check_eq("byp_rt", RegData_rt, 32'h12345678);
    next_cycle(); settle();
    check_eq("r4_hold", RegData_rs, 32'h12345678);

    // Register 0: writes ignored, issues ignored
    WB_WriteEn = 1'b1; WB_WriteAdd = 5'd0; WB_WriteData = 32'hFFFFFFFF;
    RegAdd_rs = 5'd0; settle();
    check_eq("r0_byp", RegData_rs, 32'h0);
    next_cycle(); settle();
    check_eq("r0_read", RegData_rs, 32'h0);
    Issue_Valid = 1'b1; Issue_DestAdd = 5'd0;
    next_cycle(); settle();
    check_eq("r0_haz", {31'b0, Hazard_rs}, 32'h0);
    check_eq("r0_ovf", {31'b0, Pend_Overflow}, 32'h0);

    // Issue r9, hazard next cycle, cleared by same-cycle writeback
    Issue_Valid = 1'b1; Issue_DestAdd = 5'd9; RegAdd_rs = 5'd9; RegAdd_rt = 5'd9; settle();
    check_eq("r9_issue_cyc", {31'b0, Hazard_rs}, 32'h0);
    next_cycle(); settle();
    check_eq("r9_haz_rs", {31'b0, Hazard_rs}, 32'h1);
    check_eq("r9_haz_rt", {31'b0, Hazard_rt}, 32'h1);
    WB_WriteEn = 1'b1; WB_WriteAdd = 5'd9; WB_WriteData = 32'hA5; settle();
    check_eq("r9_wb_haz", {31'b0, Hazard_rs}, 32'h0);
    check_eq("r9_wb_data", RegData_rs, 32'hA5);
    next_cycle(); settle();
    check_eq("r9_after_haz", {31'b0, Hazard_rs}, 32'h0);
    check_eq("r9_after_data", RegData_rs, 32'hA5);

    // r2 saturation: three issues fit, the fourth overflows
    RegAdd_rs = 5'd2; RegAdd_rt = 5'd0;
    for (int i = 0; i < 3; i++) begin
      Issue_Valid = 1'b1; Issue_DestAdd = 5'd2;
      next_cycle();
    end
    settle();
    check_eq("r2_ovf_at3", {31'b0, Pend_Overflow}, 32'h0);
    Issue_Valid = 1'b1; Issue_DestAdd = 5'd2;
    next_cycle(); settle();
    check_eq("r2_ovf_at4", {31'b0, Pend_Overflow}, 32'h1);
    // count 3 -> 2 -> 1; hazard stays up while more than one is in flight
    WB_WriteEn = 1'b1; WB_WriteAdd = 5'd2; WB_WriteData = 32'h21;
    next_cycle();
    WB_WriteEn = 1'b1; WB_WriteAdd = 5'd2; WB_WriteData = 32'h22; settle();
    check_eq("r2_haz_cnt2_wb", {31'b0, Hazard_rs}, 32'h1);
    next_cycle();
    WB_WriteEn = 1'b1; WB_WriteAdd = 5'd2; WB_WriteData = 32'h23; settle();
    check_eq("r2_haz_cnt1_wb", {31'b0, Hazard_rs}, 32'h0);
    next_cycle(); settle();
    check_eq("r2_haz_clear", {31'b0, Hazard_rs}, 32'h0);
    check_eq("r2_ovf_sticky", {31'b0, Pend_Overflow}, 32'h1);
    check_eq("r2_data", RegData_rs, 32'h23);

    // Same-cycle issue and writeback leaves count unchanged
    RegAdd_rs = 5'd6;
    Issue_Valid = 1'b1; Issue_DestAdd = 5'd6;
    next_cycle();
    Issue_Valid = 1'b1; Issue_DestAdd = 5'd6;
    WB_WriteEn = 1'b1; WB_WriteAdd = 5'd6; WB_WriteData = 32'h66;
    next_cycle(); settle();
    check_eq("r6_cnt_kept", {31'b0, Hazard_rs}, 32'h1);
    WB_WriteEn = 1'b1; WB_WriteAdd = 5'd6; WB_WriteData = 32'h67; settle();
    check_eq("r6_cnt_is1", {31'b0, Hazard_rs}, 32'h0);
    next_cycle(); settle();
    check_eq("r6_done", {31'b0, Hazard_rs}, 32'h0);

    // Untracked write at count 0 must not wrap
    RegAdd_rs = 5'd10;
    WB_WriteEn = 1'b1; WB_WriteAdd = 5'd10; WB_WriteData = 32'h10;
    next_cycle(); settle();
    check_eq("r10_no_wrap", {31'b0, Hazard_rs}, 32'h0);
    Issue_Valid = 1'b1; Issue_DestAdd = 5'd10;
    next_cycle(); settle();
    check_eq("r10_haz", {31'b0, Hazard_rs}, 32'h1);
    WB_WriteEn = 1'b1; WB_WriteAdd = 5'd10; WB_WriteData = 32'h11; settle();
    check_eq("r10_cnt_is1", {31'b0, Hazard_rs}, 32'h0);
    next_cycle();

`ifdef REGFILE_DEBUG_PORT_EN
    // Debug port shows raw array contents, no bypass
    Dbg_Add = 5'd31;
    WB_WriteEn = 1'b1; WB_WriteAdd = 5'd31; WB_WriteData = 32'h55; settle();
    check_eq("dbg_no_byp", Dbg_Data, 32'h0);
    next_cycle(); settle();
    check_eq("dbg_after", Dbg_Data, 32'h55);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_register_file
